stopwatch_1: RTL and testbench

Free-running seconds stopwatch with a freeze control and an end-of-minute alarm. A prescaler divides the system clock down to a one-second tick. The tick advances a 0–59 seconds counter, and `ring` is raised for a programmable number of cycles each time the count wraps. It is a leaf timing block that feeds a display or alarm driver; every output is registered.

---
 rtl/stopwatch_1.sv | 84 ++++++++
 tb/tb_stopwatch_1.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/stopwatch_1.sv
// Seconds stopwatch: a prescaler makes a one-second tick that advances a wrapping
// seconds count; each wrap raises a registered ring pulse for RING_CYCLES cycles.
module stopwatch_1 #(
  parameter int CLKS_PER_SEC = 10,
  parameter int SEC_MAX      = 59,
  parameter int RING_CYCLES  = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       stop,
  output logic       ring,
  output logic [5:0] sec
);

  localparam int DIV_W  = (CLKS_PER_SEC > 1) ? $clog2(CLKS_PER_SEC) : 1;
  localparam int RCNT_W = (RING_CYCLES > 0) ? $clog2(RING_CYCLES + 1) : 1;

  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLKS_PER_SEC - 1);
  localparam logic [5:0]        SEC_LAST  = 6'(SEC_MAX);
  localparam logic [RCNT_W-1:0] RING_LOAD = RCNT_W'(RING_CYCLES);

  logic [DIV_W-1:0]  div_q, div_d;
  logic [5:0]        sec_q, sec_d;
  logic [RCNT_W-1:0] rcnt_q, rcnt_d;
  logic              ring_q, ring_d;
  logic              tick;
  logic              wrap;

  // The prescaler simply holds under stop, so the partial second survives a freeze.
  always_comb begin
    div_d = div_q;
    tick  = 1'b0;
    if (!stop) begin
      if (div_q == DIV_LAST) begin
        div_d = '0;
        tick  = 1'b1;
      end else begin
        div_d = div_q + 1'b1;
      end
    end
  end

  always_comb begin
    sec_d = sec_q;
    wrap  = 1'b0;
    if (tick) begin
      if (sec_q >= SEC_LAST) begin
        sec_d = '0;
        wrap  = 1'b1;
      end else begin
        sec_d = sec_q + 6'd1;
      end
    end
  end

  // Ring countdown ignores stop; a fresh wrap always restarts the full pulse.
  always_comb begin
    rcnt_d = rcnt_q;
    if (wrap) begin
      rcnt_d = RING_LOAD;
    end else if (rcnt_q != '0) begin
      rcnt_d = rcnt_q - 1'b1;
    end
    ring_d = (rcnt_q != '0);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_q  <= '0;
      sec_q  <= '0;
      rcnt_q <= '0;
      ring_q <= 1'b0;
    end else begin
      div_q  <= div_d;
      sec_q  <= sec_d;
      rcnt_q <= rcnt_d;
      ring_q <= ring_d;
    end
  end

  assign sec  = sec_q;
  assign ring = ring_q;

endmodule

// File: tb/tb_stopwatch_1.sv
// Scoreboard bench for stopwatch_1: a default instance and a small-parameter
// instance share stimulus and are compared each cycle against an arithmetic model.
module tb_stopwatch_1;

  localparam int CPS_A = 10;
  localparam int MAX_A = 59;
  localparam int RING_A = 4;
  localparam int CPS_B = 2;
  localparam int MAX_B = 3;
  localparam int RING_B = 1;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       stop = 1'b0;
  logic       ringA, ringB;
  logic [5:0] secA, secB;

  stopwatch_1 dutA (
    .clk   (clk),
    .reset (reset),
    .stop  (stop),
    .ring  (ringA),
    .sec   (secA)
  );

  stopwatch_1 #(
    .CLKS_PER_SEC (CPS_B),
    .SEC_MAX      (MAX_B),
    .RING_CYCLES  (RING_B)
  ) dutB (
    .clk   (clk),
    .reset (reset),
    .stop  (stop),
    .ring  (ringB),
    .sec   (secB)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0] secA;
    logic       ringA;
    logic [5:0] secB;
    logic       ringB;
  } expT;

  expT scoreQ[$];

  int runEdges;
  int edgeNum;
  int lastWrapA;
  int lastWrapB;
  int checksDone = 0;
  int checksPassed = 0;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checksDone++;
    if (observed === expected) checksPassed++;
    else $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, observed, expected, $time);
  endtask

  task automatic modelReset();
    runEdges  = 0;
    edgeNum   = 0;
    lastWrapA = -1000;
    lastWrapB = -1000;
    scoreQ.delete();
  endtask

  // Expected values come from elapsed running edges, not from a copy of the counters.
  task automatic applyStimulus(input logic stopVal);
    expT e;
    stop = stopVal;
    edgeNum++;
    if (!stopVal) begin
      runEdges++;
      if (runEdges % (CPS_A * (MAX_A + 1)) == 0) lastWrapA = edgeNum;
      if (runEdges % (CPS_B * (MAX_B + 1)) == 0) lastWrapB = edgeNum;
    end
    e.secA  = 6'((runEdges / CPS_A) % (MAX_A + 1));
    e.ringA = (edgeNum - lastWrapA >= 1) && (edgeNum - lastWrapA <= RING_A);
    e.secB  = 6'((runEdges / CPS_B) % (MAX_B + 1));
    e.ringB = (edgeNum - lastWrapB >= 1) && (edgeNum - lastWrapB <= RING_B);
    scoreQ.push_back(e);
  endtask

  task automatic compareOutputs();
    expT e;
    if (scoreQ.size() == 0) begin
      checkOutput("scoreboardEmpty", 32'd1, 32'd0);
    end else begin
      e = scoreQ.pop_front();
      checkOutput("secA", 32'(secA), 32'(e.secA));
      checkOutput("ringA", 32'(ringA), 32'(e.ringA));
      checkOutput("secB", 32'(secB), 32'(e.secB));
      checkOutput("ringB", 32'(ringB), 32'(e.ringB));
    end
  endtask

  // Called just after a falling edge; returns just after a falling edge.
  task automatic runCycles(input int count, input logic stopVal);
    for (int i = 0; i < count; i++) begin
      applyStimulus(stopVal);
      @(posedge clk);
      #1;
      compareOutputs();
      @(negedge clk);
    end
  endtask

  initial begin
    modelReset();
    reset = 1'b0;
    stop  = 1'b0;

    repeat (3) begin
      @(posedge clk);
      #1;
      checkOutput("rstSecA", 32'(secA), 32'd0);
      checkOutput("rstRingA", 32'(ringA), 32'd0);
      checkOutput("rstSecB", 32'(secB), 32'd0);
    end

    @(negedge clk);
    reset = 1'b1;
    modelReset();

    runCycles(10, 1'b0);
    checkOutput("firstTickA", 32'(secA), 32'd1);
    runCycles(50, 1'b1);
    checkOutput("freezeHoldA", 32'(secA), 32'd1);
    runCycles(9, 1'b0);
    checkOutput("partialKeptA", 32'(secA), 32'd1);
    runCycles(1, 1'b0);
    checkOutput("resumeTickA", 32'(secA), 32'd2);

    runCycles(579, 1'b0);
    checkOutput("preWrapA", 32'(secA), 32'd59);
    runCycles(1, 1'b0);
    checkOutput("wrapA", 32'(secA), 32'd0);
    checkOutput("wrapRingLowA", 32'(ringA), 32'd0);

    runCycles(8, 1'b1);
    checkOutput("stopRingSecA", 32'(secA), 32'd0);
    checkOutput("stopRingDoneA", 32'(ringA), 32'd0);

    runCycles(602, 1'b0);
    checkOutput("midRingHighA", 32'(ringA), 32'd1);
    checkOutput("midRingSecA", 32'(secA), 32'd0);

    #2;
    reset = 1'b0;
    #1;
    checkOutput("asyncRingA", 32'(ringA), 32'd0);
    checkOutput("asyncSecA", 32'(secA), 32'd0);
    checkOutput("asyncSecB", 32'(secB), 32'd0);
    checkOutput("asyncRingB", 32'(ringB), 32'd0);
    repeat (2) begin
      @(posedge clk);
      #1;
      checkOutput("heldSecA", 32'(secA), 32'd0);
      checkOutput("heldRingA", 32'(ringA), 32'd0);
    end

    @(negedge clk);
    reset = 1'b1;
    modelReset();
    runCycles(10, 1'b0);
    checkOutput("restartTickA", 32'(secA), 32'd1);
    runCycles(10, 1'b0);
    checkOutput("restartTick2A", 32'(secA), 32'd2);
    checkOutput("restartSecB", 32'(secB), 32'd2);

    $display("%0d/%0d checks passed", checksPassed, checksDone);
    $finish;
  end

endmodule
